multi_cycle_cpu: RTL and testbench

Multi-cycle RV32I core, the parametrised successor of the team's single-cycle CPU. Each instruction is sequenced by a control FSM across fetch, decode, execute, memory and writeback cycles, and one shared req/ack memory bus carries both instruction and data traffic. The memory side may insert any number of wait states. Decode, ALU, branch-compare and register-file behaviour are unchanged from the existing blocks; only sequencing, bus handshake, reset vector and system-instruction handling are new.

---
 rtl/cpu_pkg.sv | 71 +++++++
 rtl/mc_control.sv | 74 +++++++
 rtl/multi_cycle_cpu.sv | 114 +++++++++++
 tb/tb_multi_cycle_cpu.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the multi-cycle RV32I core: FSM states,
// opcodes, immediate extraction, ALU and branch-compare helpers.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_e;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

  localparam logic [2:0] SIZE_WORD = 3'b010;

  function automatic logic [31:0] imm_i(input logic [31:0] ir);
    return {{20{ir[31]}}, ir[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] ir);
    return {{20{ir[31]}}, ir[31:25], ir[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] ir);
    return {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] ir);
    return {ir[31:12], 12'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] ir);
    return {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
  endfunction

  // alt selects SUB for add and SRA for right shifts
  function automatic logic [31:0] alu(input logic [2:0] f3, input logic alt,
                                      input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'b000:  return alt ? a - b : a + b;
      3'b001:  return a << b[4:0];
      3'b010:  return {31'b0, $signed(a) < $signed(b)};
      3'b011:  return {31'b0, a < b};
      3'b100:  return a ^ b;
      3'b101:  return alt ? $signed(a) >>> b[4:0] : a >> b[4:0];
      3'b110:  return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic logic br_taken(input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] b);
    case (f3)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) < $signed(b);
      3'b101:  return $signed(a) >= $signed(b);
      3'b110:  return a < b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_control.sv
// Instruction sequencer and bus handshake: walks FETCH/DECODE/EXEC/MEM/WB,
// produces datapath register enables, mem_req/mem_we, retire and trap flags.
module mc_control
  import cpu_pkg::*;
#(
  parameter bit HALT_ON_SYSTEM = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       halt_i,
  input  logic       mem_ack_i,
  input  logic [6:0] opcode_i,
  output state_e     state_o,
  output logic       mem_req_o,
  output logic       mem_we_o,
  output logic       ir_en_o,
  output logic       ab_en_o,
  output logic       ex_en_o,
  output logic       ld_en_o,
  output logic       wb_en_o,
  output logic       retired_o,
  output logic       trapped_o
);

  state_e state_q;
  logic   run_q, pend_q, retired_q, trapped_q;
  logic   ack;

  // run_q keeps the bus quiet in the cycle right after reset; pend_q makes an
  // issued fetch immune to halt until it is acked.
  assign mem_req_o = (state_q == S_FETCH && run_q && (pend_q || !halt_i)) ||
                     (state_q == S_MEM);
  assign mem_we_o  = (state_q == S_MEM) && (opcode_i == OPC_STORE);
  assign ack       = mem_req_o && mem_ack_i;

  assign state_o   = state_q;
  assign ir_en_o   = (state_q == S_FETCH) && ack;
  assign ab_en_o   = (state_q == S_DECODE);
  assign ex_en_o   = (state_q == S_EXEC);
  assign ld_en_o   = (state_q == S_MEM) && ack && (opcode_i == OPC_LOAD);
  assign wb_en_o   = (state_q == S_WB);
  assign retired_o = retired_q;
  assign trapped_o = trapped_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_FETCH;
      run_q     <= 1'b0;
      pend_q    <= 1'b0;
      retired_q <= 1'b0;
      trapped_q <= 1'b0;
    end else begin
      run_q     <= 1'b1;
      retired_q <= (state_q == S_WB);
      pend_q    <= (state_q == S_FETCH) && mem_req_o && !mem_ack_i;
      case (state_q)
        S_FETCH:  if (ack) state_q <= S_DECODE;
        S_DECODE: begin
          if (HALT_ON_SYSTEM && opcode_i == OPC_SYSTEM) begin
            state_q   <= S_TRAP;
            trapped_q <= 1'b1;
          end else begin
            state_q <= S_EXEC;
          end
        end
        S_EXEC:   state_q <= (opcode_i == OPC_LOAD || opcode_i == OPC_STORE) ? S_MEM : S_WB;
        S_MEM:    if (ack) state_q <= S_WB;
        S_WB:     state_q <= S_FETCH;
        default:  state_q <= S_TRAP;
      endcase
    end
  end

endmodule

// File: rtl/multi_cycle_cpu.sv
// Multi-cycle RV32I core on a single shared req/ack bus. Datapath registers
// (IR, A, B, R, next-PC) and the register file live here; mc_control sequences.
module multi_cycle_cpu
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter bit          HALT_ON_SYSTEM = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        halt_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [2:0]  mem_size_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i,
  output logic [31:0] pc_o,
  output logic [31:0] reg_a0_o,
  output logic        retired_o,
  output logic        trapped_o
);

  state_e      state;
  logic        ir_en, ab_en, ex_en, ld_en, wb_en;
  logic [31:0] pc_q, npc_q, ir_q, a_q, b_q, r_q;
  logic [31:0] rf_q [32];
  logic [31:0] r_d, npc_d;
  logic [6:0]  opc;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic        alt, writes_rd;

  assign opc = ir_q[6:0];
  assign rd  = ir_q[11:7];
  assign f3  = ir_q[14:12];
  assign rs1 = ir_q[19:15];
  assign rs2 = ir_q[24:20];

  mc_control #(.HALT_ON_SYSTEM(HALT_ON_SYSTEM)) u_ctrl (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .halt_i    (halt_i),
    .mem_ack_i (mem_ack_i),
    .opcode_i  (opc),
    .state_o   (state),
    .mem_req_o (mem_req_o),
    .mem_we_o  (mem_we_o),
    .ir_en_o   (ir_en),
    .ab_en_o   (ab_en),
    .ex_en_o   (ex_en),
    .ld_en_o   (ld_en),
    .wb_en_o   (wb_en),
    .retired_o (retired_o),
    .trapped_o (trapped_o)
  );

  // OP-IMM has no SUB, so bit 30 only matters there for SRAI
  assign alt = ir_q[30] && (opc == OPC_OP || f3 == 3'b101);
  assign writes_rd = opc inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
                                 OPC_LOAD, OPC_OP, OPC_OP_IMM};

  always_comb begin
    r_d   = pc_q + 32'd4;
    npc_d = pc_q + 32'd4;
    case (opc)
      OPC_LUI:    r_d = imm_u(ir_q);
      OPC_AUIPC:  r_d = pc_q + imm_u(ir_q);
      OPC_JAL:    npc_d = pc_q + imm_j(ir_q);
      OPC_JALR:   npc_d = (a_q + imm_i(ir_q)) & ~32'd1;
      OPC_BRANCH: if (br_taken(f3, a_q, b_q)) npc_d = pc_q + imm_b(ir_q);
      OPC_OP:     r_d = alu(f3, alt, a_q, b_q);
      OPC_OP_IMM: r_d = alu(f3, alt, a_q, imm_i(ir_q));
      OPC_LOAD:   r_d = a_q + imm_i(ir_q);
      OPC_STORE:  r_d = a_q + imm_s(ir_q);
      default:    ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q  <= RESET_PC;
      npc_q <= RESET_PC;
      ir_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      r_q   <= '0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      if (ir_en) ir_q <= mem_rdata_i;
      if (ab_en) begin
        a_q <= rf_q[rs1];
        b_q <= rf_q[rs2];
      end
      if (ex_en) begin
        r_q   <= r_d;
        npc_q <= npc_d;
      end
      if (ld_en) r_q <= mem_rdata_i;
      if (wb_en) begin
        pc_q <= npc_q;
        if (writes_rd && rd != 5'd0) rf_q[rd] <= r_q;
      end
    end
  end

  assign mem_addr_o  = (state == S_FETCH) ? pc_q : r_q;
  assign mem_size_o  = (state == S_FETCH) ? SIZE_WORD : f3;
  assign mem_wdata_o = b_q;
  assign pc_o        = pc_q;
  assign reg_a0_o    = rf_q[10];

endmodule

// File: tb/tb_multi_cycle_cpu.sv
// Bench for multi_cycle_cpu: a wait-state memory responder, a bus/retire
// monitor popping an expected-access scoreboard, and directed programs.
module tb_multi_cycle_cpu;

  logic        clk = 1'b0, rst = 1'b1, halt = 1'b0;
  logic        mem_req, mem_we, mem_ack = 1'b0, retired, trapped;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = '0, pc, reg_a0;
  logic [2:0]  mem_size;

  always #5 clk = ~clk;

  multi_cycle_cpu dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .halt_i      (halt),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_size_o  (mem_size),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata),
    .mem_ack_i   (mem_ack),
    .pc_o        (pc),
    .reg_a0_o    (reg_a0),
    .retired_o   (retired),
    .trapped_o   (trapped)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } bus_t;

  bus_t        exp_q[$];
  bus_t        prev, e_m;
  logic        prev_pend = 1'b0;
  int          ret_t[$];
  int          n_chk = 0, n_pass = 0, cyc = 0;
  logic [31:0] mem [256];
  int          fwait = 0, dwait = 0, wcnt = 0;
  logic [31:0] data_lo = 32'hFFFF_FFFF;
  logic [31:0] ECALL = 32'h0000_0073;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory responder: acks after fwait/dwait idle cycles; data region is >= data_lo
  always @(negedge clk) begin
    if (rst || !mem_req) begin
      mem_ack = 1'b0;
      wcnt    = 0;
    end else if (wcnt >= ((mem_addr >= data_lo) ? dwait : fwait)) begin
      mem_ack = 1'b1;
      if (mem_we) mem[mem_addr[9:2]] = mem_wdata;
      mem_rdata = mem[mem_addr[9:2]];
      wcnt = 0;
    end else begin
      mem_ack = 1'b0;
      wcnt++;
    end
  end

  // Monitor: bus stability while waiting, scoreboard pop on ack, retire log
  always begin
    @(negedge clk);
    #1;
    if (rst) begin
      prev_pend = 1'b0;
    end else begin
      if (prev_pend) begin
        chk("bus_hold_req", 32'(mem_req), 32'd1);
        chk("bus_hold_addr", mem_addr, prev.addr);
        chk("bus_hold_ctl", 32'({mem_we, mem_size}), 32'({prev.we, prev.size}));
        chk("bus_hold_wdata", mem_wdata, prev.wdata);
      end
      prev.we    = mem_we;
      prev.addr  = mem_addr;
      prev.size  = mem_size;
      prev.wdata = mem_wdata;
      prev_pend  = mem_req && !mem_ack;
      if (mem_req && mem_ack) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL bus_unexpected: got access at 0x%08h, want none", mem_addr);
        end else begin
          e_m = exp_q.pop_front();
          chk("bus_addr", mem_addr, e_m.addr);
          chk("bus_ctl", 32'({mem_we, mem_size}), 32'({e_m.we, e_m.size}));
          if (e_m.we) chk("bus_wdata", mem_wdata, e_m.wdata);
        end
      end
      if (retired) ret_t.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_f(input logic [31:0] a);
    bus_t b;
    b.we = 1'b0; b.addr = a; b.size = 3'b010; b.wdata = '0;
    exp_q.push_back(b);
  endtask

  task automatic exp_d(input logic we, input logic [31:0] a, input logic [31:0] wd);
    bus_t b;
    b.we = we; b.addr = a; b.size = 3'b010; b.wdata = wd;
    exp_q.push_back(b);
  endtask

  task automatic put(input logic [31:0] a, input logic [31:0] w);
    mem[a[9:2]] = w;
  endtask

  function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, int op);
    logic [31:0] im, a, f, d, o;
    im = imm; a = rs1; f = f3; d = rd; o = op;
    return {im[11:0], a[4:0], f[2:0], d[4:0], o[6:0]};
  endfunction

  function automatic logic [31:0] enc_s(int imm, int rs2, int rs1);
    logic [31:0] im, a, b;
    im = imm; a = rs1; b = rs2;
    return {im[11:5], b[4:0], a[4:0], 3'b010, im[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
    logic [31:0] im, a, b, f;
    im = imm; a = rs1; b = rs2; f = f3;
    return {im[12], im[10:5], b[4:0], a[4:0], f[2:0], im[4:1], im[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_u(int imm20, int rd, int op);
    logic [31:0] im, d, o;
    im = imm20; d = rd; o = op;
    return {im[19:0], d[4:0], o[6:0]};
  endfunction

  function automatic logic [31:0] enc_j(int imm, int rd);
    logic [31:0] im, d;
    im = imm; d = rd;
    return {im[20], im[10:1], im[11], im[19:12], d[4:0], 7'b1101111};
  endfunction

  task automatic begin_test();
    rst = 1'b1;
    halt = 1'b0;
    tick();
    exp_q.delete();
    ret_t.delete();
    foreach (mem[i]) mem[i] = '0;
  endtask

  task automatic release_rst();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_trap(input string nm, input int lim);
    int n = 0;
    while (!trapped && n < lim) begin
      tick();
      n++;
    end
    chk(nm, 32'(trapped), 32'd1);
  endtask

  task automatic quiet(input string nm);
    int busy = 0;
    repeat (6) begin
      tick();
      if (mem_req) busy++;
    end
    chk({nm, "_no_req"}, busy, 0);
    chk({nm, "_bus_all_seen"}, exp_q.size(), 0);
  endtask

  initial begin
    int n;
    int busy;
    // Reset state, addi chain, ECALL at 0x40
    begin_test();
    chk("rst_pc", pc, 32'h0);
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_retired", 32'(retired), 0);
    chk("rst_trapped", 32'(trapped), 0);
    chk("rst_a0", reg_a0, 0);
    put(32'h0, enc_i(5, 0, 0, 10, 'h13));
    put(32'h4, enc_i(7, 10, 0, 10, 'h13));
    put(32'h8, enc_j(32'h38, 0));
    put(32'h40, ECALL);
    exp_f(32'h0); exp_f(32'h4); exp_f(32'h8); exp_f(32'h40);
    release_rst();
    wait_trap("t1_trap", 100);
    chk("t1_a0", reg_a0, 32'd12);
    chk("t1_retire_cnt", ret_t.size(), 3);
    chk("t1_retire_gap", (ret_t.size() >= 2) ? ret_t[1] - ret_t[0] : -1, 4);
    chk("t1_trap_pc", pc, 32'h40);
    quiet("t1");

    // sw then lw with 3 data wait states
    begin_test();
    chk("t2_rst_clears_a0", reg_a0, 0);
    data_lo = 32'h100; dwait = 3;
    put(32'h0, enc_u(32'h12345, 5, 'h37));
    put(32'h4, enc_i(32'h678, 5, 0, 5, 'h13));
    put(32'h8, enc_s(32'h100, 5, 0));
    put(32'hC, enc_i(32'h100, 0, 2, 10, 'h03));
    put(32'h10, ECALL);
    exp_f(32'h0); exp_f(32'h4); exp_f(32'h8); exp_d(1'b1, 32'h100, 32'h12345678);
    exp_f(32'hC); exp_d(1'b0, 32'h100, 32'h0); exp_f(32'h10);
    release_rst();
    wait_trap("t2_trap", 200);
    chk("t2_a0_loaded", reg_a0, 32'h12345678);
    chk("t2_sw_cycles", (ret_t.size() >= 4) ? ret_t[2] - ret_t[1] : -1, 8);
    chk("t2_lw_cycles", (ret_t.size() >= 4) ? ret_t[3] - ret_t[2] : -1, 8);
    chk("t2_trap_pc", pc, 32'h10);
    quiet("t2");
    data_lo = 32'hFFFF_FFFF; dwait = 0;

    // beq x10,x0,-8 at 0x20: taken when x10==0, falls through otherwise
    for (int k = 0; k < 2; k++) begin
      begin_test();
      put(32'h0, enc_i(k, 0, 0, 10, 'h13));
      put(32'h4, enc_j(32'h1C, 0));
      put(32'h20, enc_b(-8, 0, 10, 0));
      put(32'h18, ECALL);
      put(32'h24, ECALL);
      exp_f(32'h0); exp_f(32'h4); exp_f(32'h20); exp_f(k == 0 ? 32'h18 : 32'h24);
      release_rst();
      wait_trap("t3_trap", 100);
      chk(k == 0 ? "t3_taken_pc" : "t3_fall_pc", pc, k == 0 ? 32'h18 : 32'h24);
      quiet("t3");
    end

    // jalr x1,4(x5) with x5=0x103: target 0x106, link 8 exposed by a store
    begin_test();
    put(32'h0, enc_i(32'h103, 0, 0, 5, 'h13));
    put(32'h4, enc_i(4, 5, 0, 1, 'h67));
    put(32'h106, enc_s(32'h200, 1, 0));
    put(32'h10A, ECALL);
    exp_f(32'h0); exp_f(32'h4); exp_f(32'h106); exp_d(1'b1, 32'h200, 32'h8); exp_f(32'h10A);
    release_rst();
    wait_trap("t4_trap", 100);
    chk("t4_trap_pc", pc, 32'h10A);
    quiet("t4");

    // halt raised during a load's wait states
    begin_test();
    data_lo = 32'h100; dwait = 3;
    put(32'h0, enc_i(32'h100, 0, 2, 10, 'h03));
    put(32'h4, enc_i(1, 10, 0, 10, 'h13));
    put(32'h8, ECALL);
    put(32'h100, 32'hCAFE_F00D);
    exp_f(32'h0); exp_d(1'b0, 32'h100, 32'h0); exp_f(32'h4); exp_f(32'h8);
    release_rst();
    n = 0;
    while (!(mem_req && !mem_we && mem_addr == 32'h100) && n < 50) begin
      tick();
      n++;
    end
    chk("t5_saw_load_req", 32'(mem_req), 1);
    halt = 1'b1;
    n = 0;
    while (!retired && n < 50) begin
      tick();
      n++;
    end
    chk("t5_load_retired", 32'(retired), 1);
    chk("t5_a0_loaded", reg_a0, 32'hCAFE_F00D);
    busy = 0;
    repeat (10) begin
      tick();
      if (mem_req) busy++;
    end
    chk("t5_halt_no_req", busy, 0);
    chk("t5_halt_pc", pc, 32'h4);
    halt = 1'b0;
    wait_trap("t5_trap", 100);
    chk("t5_a0_resumed", reg_a0, 32'hCAFE_F00E);
    chk("t5_trap_pc", pc, 32'h8);
    quiet("t5");
    data_lo = 32'hFFFF_FFFF; dwait = 0;

    // reset in the middle of a waiting fetch
    begin_test();
    fwait = 3;
    put(32'h0, enc_i(5, 0, 0, 10, 'h13));
    put(32'h4, enc_i(7, 10, 0, 10, 'h13));
    exp_f(32'h0);
    release_rst();
    n = 0;
    while (!retired && n < 60) begin
      tick();
      n++;
    end
    chk("t6_first_retired", 32'(retired), 1);
    chk("t6_fetch_pending", 32'(mem_req && mem_addr == 32'h4), 1);
    rst = 1'b1;
    tick();
    chk("t6_req_dropped", 32'(mem_req), 0);
    chk("t6_pc_reset", pc, 32'h0);
    chk("t6_bus_all_seen", exp_q.size(), 0);
    fwait = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of run, want $finish before 200000");
    $fatal(1);
  end

endmodule
